// File: rtl/wb_pkg.sv
// Shared writeback definitions: widths, write-select encodings and FSM states.
// Also used by the MEM/WB pipeline register and the hazard unit.
package wb_pkg;

    localparam int XLEN    = 32;
    localparam int MAT_W   = 128;
    localparam int RADDR_W = 5;
    localparam int NBEATS  = MAT_W / XLEN;

    localparam logic [1:0] W_SEL_NONE   = 2'b00;
    localparam logic [1:0] W_SEL_SCALAR = 2'b01;
    localparam logic [1:0] W_SEL_MATRIX = 2'b10;
    localparam logic [1:0] W_SEL_RSVD   = 2'b11;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_MAT  = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_writeback_unit.sv
// Writeback stage: drives the integer register-file write port from either the
// scalar result (zero latency) or the matrix result, serialised one XLEN word
// per cycle. The upstream pipeline is stalled while a matrix writeback drains.
//
// state   | meaning
// --------+-------------------------------------------------------------
// WB_IDLE | accepting a new instruction; scalar or matrix beat 0 written
// WB_MAT  | draining latched matrix words 1..NBEATS-1, inputs ignored
module wb_writeback_unit
    import wb_pkg::*;
#(
    parameter int XLEN    = wb_pkg::XLEN,
    parameter int MAT_W   = wb_pkg::MAT_W,
    parameter int RADDR_W = wb_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN-1:0]    wb_mem_data,
    input  logic [XLEN-1:0]    wb_alu_o,
    input  logic [MAT_W-1:0]   wb_matrix_o,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic               wb_mem2reg,
    input  logic [1:0]         wb_w_select,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               wb_stall,
    output logic               wb_mat_done
);

    localparam int NB     = MAT_W / XLEN;
    localparam int BEAT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int HOLD_W = MAT_W - XLEN;

    wb_state_e           state_q, state_d;
    logic [BEAT_W-1:0]   beat_q;
    logic [RADDR_W-1:0]  base_q;
    // Words 1..NB-1; shifted down one word per beat so the current word is always at the bottom.
    logic [HOLD_W-1:0]   hold_q;

    logic                load_mat;
    logic                advance;
    logic                we_raw;
    logic                last_beat;

    assign last_beat = (beat_q == BEAT_W'(NB - 1));

    // State, beat counter, base register and matrix holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WB_IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_mat) begin
                base_q <= wb_rd;
                hold_q <= wb_matrix_o[MAT_W-1:XLEN];
                beat_q <= BEAT_W'(1);
            end else if (advance) begin
                hold_q <= hold_q >> XLEN;
                beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
            end
        end
    end

    // Next-state and write-port outputs; x0 writes are suppressed but still take their cycle.
    always_comb begin
        state_d     = state_q;
        load_mat    = 1'b0;
        advance     = 1'b0;
        we_raw      = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        wb_stall    = 1'b0;
        wb_mat_done = 1'b0;

        case (state_q)
            WB_IDLE: begin
                case (wb_w_select)
                    W_SEL_SCALAR: begin
                        we_raw   = 1'b1;
                        rf_waddr = wb_rd;
                        rf_wdata = wb_mem2reg ? wb_mem_data : wb_alu_o;
                    end
                    W_SEL_MATRIX: begin
                        we_raw   = 1'b1;
                        rf_waddr = wb_rd;
                        rf_wdata = wb_matrix_o[XLEN-1:0];
                        wb_stall = 1'b1;
                        load_mat = 1'b1;
                        state_d  = WB_MAT;
                    end
                    default: ;
                endcase
            end
            WB_MAT: begin
                we_raw   = 1'b1;
                rf_waddr = base_q + RADDR_W'(beat_q);
                rf_wdata = hold_q[XLEN-1:0];
                advance  = 1'b1;
                if (last_beat) begin
                    wb_mat_done = 1'b1;
                    state_d     = WB_IDLE;
                end else begin
                    wb_stall = 1'b1;
                end
            end
            default: state_d = WB_IDLE;
        endcase

        rf_we = we_raw && (rf_waddr != '0);

        // Outputs are forced quiet for as long as reset is held, not just at its edge.
        if (rst) begin
            rf_we       = 1'b0;
            rf_waddr    = '0;
            rf_wdata    = '0;
            wb_stall    = 1'b0;
            wb_mat_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Directed bench for wb_writeback_unit: inputs change on the falling edge and
// the combinational outputs are checked 1 ns later, well away from the rising edge.
module tb_wb_writeback_unit;

    logic         clk;
    logic         rst;
    logic [31:0]  wb_mem_data;
    logic [31:0]  wb_alu_o;
    logic [127:0] wb_matrix_o;
    logic [4:0]   wb_rd;
    logic         wb_mem2reg;
    logic [1:0]   wb_w_select;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic         wb_stall;
    logic         wb_mat_done;

    int n_assert;
    int n_fail;

    wb_writeback_unit dut (
        .clk         (clk),
        .rst         (rst),
        .wb_mem_data (wb_mem_data),
        .wb_alu_o    (wb_alu_o),
        .wb_matrix_o (wb_matrix_o),
        .wb_rd       (wb_rd),
        .wb_mem2reg  (wb_mem2reg),
        .wb_w_select (wb_w_select),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .wb_stall    (wb_stall),
        .wb_mat_done (wb_mat_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic we, input logic [4:0] a,
                           input logic [31:0] d, input logic st, input logic dn);
        chk({tag, ".we"},    32'(rf_we),       32'(we));
        chk({tag, ".waddr"}, 32'(rf_waddr),    32'(a));
        chk({tag, ".wdata"}, rf_wdata,         d);
        chk({tag, ".stall"}, 32'(wb_stall),    32'(st));
        chk({tag, ".done"},  32'(wb_mat_done), 32'(dn));
    endtask

    task automatic drive(input logic [1:0] sel, input logic [4:0] rd, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [127:0] mat);
        wb_w_select = sel;
        wb_rd       = rd;
        wb_mem2reg  = m2r;
        wb_alu_o    = alu;
        wb_mem_data = mem;
        wb_matrix_o = mat;
    endtask

    // Advance to the next falling edge (one rising edge in between), then apply inputs.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    localparam logic [127:0] MAT_A = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [127:0] MAT_B = 128'h8888_8888_7777_7777_6666_6666_5555_5555;
    localparam logic [127:0] MAT_X = 128'hDEAD_0003_DEAD_0002_DEAD_0001_DEAD_0000;

    initial begin
        logic [31:0] exp_d;
        logic [4:0]  exp_a;
        n_assert = 0;
        n_fail   = 0;

        // Reset held with a live scalar request on the inputs: outputs must stay quiet.
        rst = 1'b1;
        drive(2'b01, 5'd5, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF, MAT_A);
        next_cycle(); #1;
        chk_out("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        next_cycle();
        rst = 1'b0;

        // Scalar from ALU, then from memory, zero latency.
        drive(2'b01, 5'd5, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF, MAT_A); #1;
        chk_out("scalar_alu", 1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b0);
        next_cycle();
        drive(2'b01, 5'd5, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, MAT_A); #1;
        chk_out("scalar_mem", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Matrix to x8..x11; later beats present different inputs, which must be ignored.
        next_cycle();
        drive(2'b10, 5'd8, 1'b0, 32'h0, 32'h0, MAT_A); #1;
        chk_out("mat_b0", 1'b1, 5'd8, 32'h1111_1111, 1'b1, 1'b0);
        next_cycle();
        drive(2'b01, 5'd3, 1'b0, 32'hCAFE_0000, 32'h0, MAT_X); #1;
        chk_out("mat_b1", 1'b1, 5'd9, 32'h2222_2222, 1'b1, 1'b0);
        next_cycle(); #1;
        chk_out("mat_b2", 1'b1, 5'd10, 32'h3333_3333, 1'b1, 1'b0);
        next_cycle(); #1;
        chk_out("mat_b3", 1'b1, 5'd11, 32'h4444_4444, 1'b0, 1'b1);
        next_cycle();
        drive(2'b00, 5'd9, 1'b0, 32'h5555_0000, 32'h0, MAT_A); #1;
        chk_out("after_mat_none", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        // Matrix wrapping 30,31,0,1; the x0 beat is suppressed but still takes its cycle.
        next_cycle();
        drive(2'b10, 5'd30, 1'b0, 32'h0, 32'h0, MAT_A); #1;
        chk_out("wrap_b0", 1'b1, 5'd30, 32'h1111_1111, 1'b1, 1'b0);
        next_cycle(); #1;
        chk_out("wrap_b1", 1'b1, 5'd31, 32'h2222_2222, 1'b1, 1'b0);
        next_cycle(); #1;
        chk_out("wrap_b2", 1'b0, 5'd0, 32'h3333_3333, 1'b1, 1'b0);
        next_cycle(); #1;
        chk_out("wrap_b3", 1'b1, 5'd1, 32'h4444_4444, 1'b0, 1'b1);

        // Scalar to x0, then none and reserved encodings.
        next_cycle();
        drive(2'b01, 5'd0, 1'b0, 32'h1234_5678, 32'h0, MAT_A); #1;
        chk_out("scalar_x0", 1'b0, 5'd0, 32'h1234_5678, 1'b0, 1'b0);
        next_cycle();
        drive(2'b00, 5'd7, 1'b0, 32'h1234_5678, 32'h0, MAT_A); #1;
        chk_out("sel_none", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        next_cycle();
        drive(2'b11, 5'd7, 1'b1, 32'h1234_5678, 32'h9999_0000, MAT_A); #1;
        chk_out("sel_rsvd", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        // Reset asserted mid-matrix, between clock edges, after beat 1.
        next_cycle();
        drive(2'b10, 5'd8, 1'b0, 32'h0, 32'h0, MAT_A); #1;
        chk_out("rmid_b0", 1'b1, 5'd8, 32'h1111_1111, 1'b1, 1'b0);
        next_cycle(); #1;
        chk_out("rmid_b1", 1'b1, 5'd9, 32'h2222_2222, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk_out("rmid_rst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        next_cycle(); #1;
        chk_out("rmid_rst_held", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(2'b01, 5'd7, 1'b0, 32'h0BAD_F00D, 32'h0, MAT_A); #1;
        chk_out("rmid_scalar", 1'b1, 5'd7, 32'h0BAD_F00D, 1'b0, 1'b0);

        // Back-to-back: matrix A to x4.., matrix B to x12.., then scalar on cycle 9.
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            if (k < 4) drive(2'b10, 5'd4, 1'b0, 32'h0, 32'h0, MAT_A);
            else       drive(2'b10, 5'd12, 1'b0, 32'h0, 32'h0, MAT_B);
            #1;
            if (k < 4) begin
                exp_a = 5'd4 + 5'(k);
                exp_d = MAT_A[32*k +: 32];
            end else begin
                exp_a = 5'd12 + 5'(k - 4);
                exp_d = MAT_B[32*(k-4) +: 32];
            end
            chk_out($sformatf("b2b_beat%0d", k), 1'b1, exp_a, exp_d,
                    (k % 4) != 3, (k % 4) == 3);
        end
        next_cycle();
        drive(2'b01, 5'd20, 1'b1, 32'h0, 32'hA5A5_5A5A, MAT_A); #1;
        chk_out("b2b_scalar", 1'b1, 5'd20, 32'hA5A5_5A5A, 1'b0, 1'b0);

        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
